// File: rtl/funpack_seq.sv
// funpack_seq -- sequential floating-point operand unpacker.
//
// Accepts one raw FP operand (single, double or half, narrower formats
// NaN-boxed in a 64-bit register), splits it into sign / biased exponent /
// mantissa, derives the class flags, and for subnormals runs a one-bit-per-
// cycle leading-zero scan to produce a normalised fraction.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous abort back to IDLE, discards any result
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   X, Fmt            raw operand and format (00 S, 01 D, 10 H, 11 -> D)
//   out_valid/out_ready result handshake (valid only in DONE)
//   Xs, Xe, Xm        sign, zero-extended biased exponent, {implicit, frac}
//   XNaN..XInf        class flags
//   Lzc, NFrac        subnormal leading-zero count and normalised fraction
module funpack_seq #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] X,
  input  logic [1:0]      Fmt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            Xs,
  output logic [10:0]     Xe,
  output logic [52:0]     Xm,
  output logic            XNaN,
  output logic            XSNaN,
  output logic            XSubnorm,
  output logic            XZero,
  output logic            XInf,
  output logic [5:0]      Lzc,
  output logic [51:0]     NFrac
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic        xs_reg;
  logic [10:0] xe_reg;
  logic [52:0] xm_reg;
  logic        xnan_reg, xsnan_reg, xsub_reg, xzero_reg, xinf_reg;
  logic [51:0] scan_reg;
  logic [5:0]  cnt_reg;

  // Combinational field extraction from the live input; registered on accept.
  logic        dec_s;
  logic [10:0] dec_e;
  logic [51:0] dec_fa;     // fraction left-aligned to 52 bits
  logic        dec_emax;   // exponent all ones for the selected format
  logic        dec_ezero;
  logic        dec_fzero;
  logic        dec_sub;

  always_comb begin
    dec_s    = 1'b0;
    dec_e    = 11'd0;
    dec_fa   = 52'd0;
    dec_emax = 1'b0;
    case (Fmt)
      2'b00: begin
        if (&X[63:32]) begin
          dec_s    = X[31];
          dec_e    = {3'b000, X[30:23]};
          dec_fa   = {X[22:0], 29'd0};
          dec_emax = &X[30:23];
        end else begin
          // Improperly boxed: substitute the canonical quiet NaN.
          dec_s    = 1'b0;
          dec_e    = 11'h0FF;
          dec_fa   = {1'b1, 51'd0};
          dec_emax = 1'b1;
        end
      end
      2'b10: begin
        if (&X[63:16]) begin
          dec_s    = X[15];
          dec_e    = {6'd0, X[14:10]};
          dec_fa   = {X[9:0], 42'd0};
          dec_emax = &X[14:10];
        end else begin
          dec_s    = 1'b0;
          dec_e    = 11'h01F;
          dec_fa   = {1'b1, 51'd0};
          dec_emax = 1'b1;
        end
      end
      default: begin
        // Double, and the reserved encoding treated as double.
        dec_s    = X[63];
        dec_e    = X[62:52];
        dec_fa   = X[51:0];
        dec_emax = &X[62:52];
      end
    endcase
    dec_ezero = (dec_e == 11'd0);
    dec_fzero = (dec_fa == 52'd0);
    dec_sub   = dec_ezero & ~dec_fzero;
  end

  logic accept;
  assign accept = (state_reg == IDLE) & in_valid & ~flush;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = dec_sub ? SCAN : DONE;
      SCAN: if (scan_reg[51]) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath. The scan register doubles as NFrac: for normal operands it
  // simply holds the left-aligned fraction, for subnormals it ends up
  // shifted past the leading one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs_reg    <= 1'b0;
      xe_reg    <= 11'd0;
      xm_reg    <= 53'd0;
      xnan_reg  <= 1'b0;
      xsnan_reg <= 1'b0;
      xsub_reg  <= 1'b0;
      xzero_reg <= 1'b0;
      xinf_reg  <= 1'b0;
      scan_reg  <= 52'd0;
      cnt_reg   <= 6'd0;
    end else if (accept) begin
      xs_reg    <= dec_s;
      xe_reg    <= dec_e;
      xm_reg    <= {~dec_ezero, dec_fa};
      xnan_reg  <= dec_emax & ~dec_fzero;
      xsnan_reg <= dec_emax & ~dec_fzero & ~dec_fa[51];
      xsub_reg  <= dec_sub;
      xzero_reg <= dec_ezero & dec_fzero;
      xinf_reg  <= dec_emax & dec_fzero;
      scan_reg  <= dec_fa;
      cnt_reg   <= 6'd0;
    end else if (state_reg == SCAN && !flush) begin
      // The final shift also discards the leading one itself.
      scan_reg <= scan_reg << 1;
      if (!scan_reg[51]) cnt_reg <= cnt_reg + 6'd1;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign Xs        = xs_reg;
  assign Xe        = xe_reg;
  assign Xm        = xm_reg;
  assign XNaN      = xnan_reg;
  assign XSNaN     = xsnan_reg;
  assign XSubnorm  = xsub_reg;
  assign XZero     = xzero_reg;
  assign XInf      = xinf_reg;
  assign Lzc       = cnt_reg;
  assign NFrac     = scan_reg;

endmodule

// File: tb/tb_funpack_seq.sv
// tb_funpack_seq -- directed self-checking bench for funpack_seq.
module tb_funpack_seq;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] X;
  logic [1:0]  Fmt;
  logic        in_ready, out_valid;
  logic        Xs;
  logic [10:0] Xe;
  logic [52:0] Xm;
  logic        XNaN, XSNaN, XSubnorm, XZero, XInf;
  logic [5:0]  Lzc;
  logic [51:0] NFrac;
  logic [4:0]  flags;

  int n_run  = 0;
  int n_fail = 0;

  assign flags = {XNaN, XSNaN, XSubnorm, XZero, XInf};

  always #5 clk = ~clk;

  funpack_seq #(.FLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Fmt(Fmt),
    .out_valid(out_valid), .out_ready(out_ready),
    .Xs(Xs), .Xe(Xe), .Xm(Xm),
    .XNaN(XNaN), .XSNaN(XSNaN), .XSubnorm(XSubnorm), .XZero(XZero), .XInf(XInf),
    .Lzc(Lzc), .NFrac(NFrac)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operand at a falling edge once the unit is ready; it is
  // accepted on the following rising edge (end of cycle 0).
  task automatic offer(input logic [63:0] x, input logic [1:0] fmt);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("offer_ready", {63'd0, in_ready}, 64'd1);
    X = x; Fmt = fmt; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles after acceptance until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [63:0] x, input logic [1:0] fmt,
                        input int exp_lat, input logic exp_s, input logic [10:0] exp_e,
                        input logic [52:0] exp_m, input logic [4:0] exp_fl,
                        input logic [5:0] exp_lzc, input logic [51:0] exp_nf);
    int lat;
    offer(x, fmt);
    wait_out(lat);
    check({name, ".lat"}, 64'(lat), 64'(exp_lat));
    check({name, ".Xs"}, {63'd0, Xs}, {63'd0, exp_s});
    check({name, ".Xe"}, {53'd0, Xe}, {53'd0, exp_e});
    check({name, ".Xm"}, {11'd0, Xm}, {11'd0, exp_m});
    check({name, ".flags"}, {59'd0, flags}, {59'd0, exp_fl});
    check({name, ".Lzc"}, {58'd0, Lzc}, {58'd0, exp_lzc});
    check({name, ".NFrac"}, {12'd0, NFrac}, {12'd0, exp_nf});
    $display("[TB] %s X=0x%h Fmt=%0d lat=%0d Xs=%0d Xe=0x%0h Xm=0x%0h flags=%b Lzc=%0d NFrac=0x%0h",
             name, x, fmt, lat, Xs, Xe, Xm, flags, Lzc, NFrac);
    consume();
  endtask

  // flags order: {NaN, SNaN, Subnorm, Zero, Inf}
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    X = 64'd0; Fmt = 2'b01;
    repeat (2) @(negedge clk);
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.Xm", {11'd0, Xm}, 64'd0);
    $display("[TB] reset state in_ready=%0d out_valid=%0d", in_ready, out_valid);
    reset = 1'b0;

    run_op("d_one", 64'h3FF0000000000000, 2'b01, 1, 1'b0, 11'h3FF,
           53'h10000000000000, 5'b00000, 6'd0, 52'd0);
    run_op("d_sub1", 64'h0000000000000001, 2'b01, 53, 1'b0, 11'h000,
           53'h00000000000001, 5'b00100, 6'd51, 52'd0);
    run_op("s_unboxed", 64'h000000003F800000, 2'b00, 1, 1'b0, 11'h0FF,
           53'h18000000000000, 5'b10000, 6'd0, 52'h8000000000000);
    run_op("s_snan", 64'hFFFFFFFF7F800001, 2'b00, 1, 1'b0, 11'h0FF,
           53'h10000020000000, 5'b11000, 6'd0, 52'h0000020000000);
    run_op("h_negzero", 64'hFFFFFFFFFFFF8000, 2'b10, 1, 1'b1, 11'h000,
           53'h0, 5'b00010, 6'd0, 52'd0);
    run_op("d_sub2", 64'h0004000000000003, 2'b01, 3, 1'b0, 11'h000,
           53'h0004000000000003, 5'b00100, 6'd1, 52'hC);
    run_op("h_sub", 64'hFFFFFFFFFFFF0001, 2'b10, 11, 1'b0, 11'h000,
           53'h40000000000, 5'b00100, 6'd9, 52'd0);
    run_op("r_neginf", 64'hFFF0000000000000, 2'b11, 1, 1'b1, 11'h7FF,
           53'h10000000000000, 5'b00001, 6'd0, 52'd0);

    // Backpressure: result must hold for 10 cycles with out_ready low.
    begin
      int lat;
      offer(64'h3FF0000000000000, 2'b01);
      wait_out(lat);
      check("bp.lat", 64'(lat), 64'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp.out_valid", {63'd0, out_valid}, 64'd1);
        check("bp.in_ready", {63'd0, in_ready}, 64'd0);
        check("bp.Xe", {53'd0, Xe}, 64'h3FF);
        check("bp.Xm", {11'd0, Xm}, 64'h10000000000000);
      end
      $display("[TB] backpressure held 10 cycles out_valid=%0d Xe=0x%0h", out_valid, Xe);
      consume();
    end

    // Flush in cycle 20 of a long subnormal scan.
    offer(64'h0000000000000001, 2'b01);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_scan.out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_scan.in_ready", {63'd0, in_ready}, 64'd1);
    $display("[TB] flush mid-scan in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_op("after_flush", 64'h3FF0000000000000, 2'b01, 1, 1'b0, 11'h3FF,
           53'h10000000000000, 5'b00000, 6'd0, 52'd0);

    // Reset in cycle 20 of the scan; an operand offered during reset is ignored.
    offer(64'h0000000000000001, 2'b01);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    X = 64'h3FF0000000000000; Fmt = 2'b01; in_valid = 1'b1;
    #1;
    check("rst_scan.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_scan.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_scan.Lzc", {58'd0, Lzc}, 64'd0);
    check("rst_scan.Xm", {11'd0, Xm}, 64'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_scan.idle", {63'd0, in_ready}, 64'd1);
    check("rst_scan.no_accept", {63'd0, out_valid}, 64'd0);
    $display("[TB] reset mid-scan in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_op("after_reset", 64'h0000000000000001, 2'b01, 53, 1'b0, 11'h000,
           53'h00000000000001, 5'b00100, 6'd51, 52'd0);

    // Flush beats a simultaneous in_valid.
    @(negedge clk);
    X = 64'h3FF0000000000000; Fmt = 2'b01; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_in.in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_in.out_valid", {63'd0, out_valid}, 64'd0);
    $display("[TB] flush vs in_valid in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // Flush discards a pending result in DONE.
    begin
      int lat;
      offer(64'hFFF0000000000000, 2'b01);
      wait_out(lat);
      check("flush_done.lat", 64'(lat), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_done.out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_done.in_ready", {63'd0, in_ready}, 64'd1);
      $display("[TB] flush in DONE out_valid=%0d in_ready=%0d", out_valid, in_ready);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/funpack_seq.md
FUNPACK_SEQ -- requirements
Module: funpack_seq

Interface
REQ-001 SHALL have one parameter: FLEN, default 64, FP register width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port flush, input, 1, synchronous abort to IDLE.
REQ-005 SHALL have port in_valid, input, 1, operand offered.
REQ-006 SHALL have port in_ready, output, 1, unit can accept an operand.
REQ-007 SHALL have port X, input, FLEN, raw operand (NaN-boxed for narrower formats).
REQ-008 SHALL have port Fmt, input, 2, format: 00 single, 01 double, 10 half, 11 reserved (treated as double).
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port Xs, output, 1, sign.
REQ-012 SHALL have port Xe, output, 11, raw biased exponent, zero-extended.
REQ-013 SHALL have port Xm, output, 53, {implicit bit, fraction left-aligned to 52 bits}.
REQ-014 SHALL have ports XNaN, XSNaN, XSubnorm, XZero and XInf, all output, 1 each, class flags in the form consumed by the classify unit.
REQ-015 SHALL have port Lzc, output, 6, leading-zero count of the left-aligned 52-bit fraction (subnormal only, else 0).
REQ-016 SHALL have port NFrac, output, 52, left-aligned fraction shifted left by Lzc+1 (subnormal), else equal to Xm[51:0].

Function
REQ-017 SHALL implement FSM states IDLE, SCAN and DONE; in_ready = (state==IDLE).
REQ-018 SHALL accept an operand on a cycle with in_valid & in_ready & ~flush ("cycle 0") and latch X and Fmt.
REQ-019 SHALL extract fields per format.
- Single: exponent X[30:23], fraction X[22:0].
- Double: exponent X[62:52], fraction X[51:0].
- Half: exponent X[14:10], fraction X[9:0].
- Sign: bit 31 (single), bit 63 (double), bit 15 (half).
REQ-020 SHALL treat an operand as unboxed when:
- Single: X[63:32] is not all ones.
- Half: X[63:16] is not all ones.
REQ-021 SHALL replace an unboxed operand with the canonical quiet NaN: Xs=0, exponent all ones for the format, fraction MSB=1 and all other fraction bits 0.
REQ-022 SHALL define the class flags as follows.
- XInf = exponent all ones & fraction 0.
- XNaN = exponent all ones & fraction != 0.
- XSNaN = XNaN & fraction MSB==0.
- XZero = exponent 0 & fraction 0.
- XSubnorm = exponent 0 & fraction != 0.
- The implicit bit = exponent != 0.
REQ-023 SHALL go from IDLE to DONE after acceptance for a non-subnormal operand, with out_valid high in cycle 1 and Lzc=0.
REQ-024 SHALL go from IDLE to SCAN after acceptance for a subnormal operand, loading a 52-bit scan register with the left-aligned fraction and a 6-bit counter with 0.
REQ-025 SHALL, on each SCAN edge:
- if scan[51]==1: shift scan left by 1, then go to DONE;
- otherwise: shift left by 1 and increment the counter.
REQ-026 SHALL, as a result of REQ-025, raise out_valid first in cycle Lzc+2 for a subnormal operand, with NFrac = fraction << (Lzc+1), truncated to 52 bits.
REQ-027 SHALL hold all outputs stable in DONE while out_valid & ~out_ready (backpressure, no limit).
REQ-028 SHALL go from DONE to IDLE on out_valid & out_ready; in_ready rises the next cycle (no same-cycle re-accept).
REQ-029 SHALL go to IDLE on flush from any state; flush wins over a simultaneous in_valid or out_ready, and the pending result is discarded (out_valid=0 next cycle).
REQ-030 SHALL drive out_valid=0 outside DONE; result outputs are don't-care when out_valid=0.

Reset
REQ-031 SHALL, on reset assertion at any time (including mid-SCAN), immediately enter IDLE and clear all of the following to 0: out_valid, Xs, Xe, Xm, flags, Lzc, NFrac, the scan register and the counter.
REQ-032 SHALL drive in_ready=1 while reset is held and after release, and accept nothing while reset is high.

Verification
REQ-033 SHALL cover: Fmt=01, X=0x3FF0000000000000 -> out_valid in cycle 1, Xs=0, Xe=0x3FF, Xm=0x10000000000000, all flags 0, Lzc=0.
REQ-034 SHALL cover: Fmt=01, X=0x0000000000000001 -> XSubnorm=1, Lzc=51, out_valid first in cycle 53, NFrac=0, Xe=0.
REQ-035 SHALL cover: Fmt=00, X=0x000000003F800000 (unboxed) -> XNaN=1, XSNaN=0, Xs=0, Xe=0x0FF, Xm[51]=1.
REQ-036 SHALL cover: Fmt=00, X=0xFFFFFFFF7F800001 -> XNaN=1, XSNaN=1, Xe=0x0FF; and Fmt=10, X=0xFFFFFFFFFFFF8000 -> Xs=1, XZero=1.
REQ-037 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable and in_ready=0 throughout; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 SHALL cover: reset or flush pulsed in cycle 20 of the REQ-034 scan -> out_valid=0 and in_ready=1 the next cycle; a new operand is then accepted normally.
